// File: rtl/capture_trigger_buffer_pkg.sv
// capture_trigger_buffer_pkg: state encoding and default widths shared by the capture buffer,
// the FIR front end and the board top level.
package capture_trigger_buffer_pkg;

    localparam int NB_DATA_DEF = 14;
    localparam int NB_ADDR_DEF = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/capture_trigger_buffer_rise_detect.sv
// capture_trigger_buffer_rise_detect: one-cycle pulse on a 0->1 transition of a synchronous level.
module capture_trigger_buffer_rise_detect (
    input  logic clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_rise
);

    logic level_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) level_q <= 1'b0;
        else          level_q <= i_level;
    end

    assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/capture_trigger_buffer.sv
// capture_trigger_buffer: trigger-armed circular sample capture with pre-trigger window,
// single-shot / auto re-arm modes and an in-order readout port with a last flag.
module capture_trigger_buffer
    import capture_trigger_buffer_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_arm,
    input  logic               i_mode,
    input  logic               i_trigger,
    input  logic [NB_ADDR-1:0] i_pretrig,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_rd_en,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_rd_valid,
    output logic               o_rd_last,
    output logic               o_full,
    output logic [1:0]         o_state,
    output logic [NB_ADDR-1:0] o_trig_index
);

    localparam int DEPTH = 2**NB_ADDR;

    state_t             state, next_state;
    logic               rise;
    logic               arm_load, accept, wr_en, rd_fire, last_fire, cap_done;
    logic [NB_ADDR-1:0] wptr, rptr, pre_cnt, rd_cnt, p_lat, start_addr;
    logic [NB_ADDR:0]   post_cnt;
    logic [NB_DATA-1:0] rd_data;
    logic               rd_valid, rd_last;
    logic [NB_DATA-1:0] mem [DEPTH];

    capture_trigger_buffer_rise_detect u_rise (
        .clock   (clock),
        .i_reset (i_reset),
        .i_level (i_trigger),
        .o_rise  (rise)
    );

    // A trigger-cycle sample already counts as the first post-trigger write, so with
    // P = DEPTH-1 post_cnt can be zero on entry and CAPTURE must still terminate.
    always_comb begin
        rd_fire    = (state == DONE) && i_rd_en;
        last_fire  = rd_fire && (&rd_cnt);
        accept     = (state == ARMED) && rise && (pre_cnt == p_lat);
        wr_en      = i_valid && ((state == ARMED) || ((state == CAPTURE) && (post_cnt != '0)));
        cap_done   = (state == CAPTURE) && ((post_cnt == '0) || (i_valid && (post_cnt == (NB_ADDR+1)'(1))));
        arm_load   = ((state == IDLE) && i_arm) || (last_fire && i_mode);
        next_state = state;
        if ((state == IDLE) && i_arm) next_state = ARMED;
        if (accept)                   next_state = CAPTURE;
        if (cap_done)                 next_state = DONE;
        if (last_fire)                next_state = i_mode ? ARMED : IDLE;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            wptr       <= '0;
            rptr       <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            rd_cnt     <= '0;
            p_lat      <= '0;
            start_addr <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            if (arm_load) begin
                wptr    <= '0;
                pre_cnt <= '0;
                p_lat   <= i_pretrig;
            end else begin
                if (wr_en) wptr <= wptr + 1'b1;
                if ((state == ARMED) && i_valid && (pre_cnt != p_lat)) pre_cnt <= pre_cnt + 1'b1;
            end
            if (accept) begin
                start_addr <= wptr - p_lat;
                post_cnt   <= (NB_ADDR+1)'(DEPTH) - (NB_ADDR+1)'(p_lat) - (NB_ADDR+1)'(i_valid);
            end else if ((state == CAPTURE) && wr_en) begin
                post_cnt <= post_cnt - 1'b1;
            end
            if (cap_done) begin
                rptr   <= start_addr;
                rd_cnt <= '0;
            end else if (rd_fire) begin
                rptr   <= rptr + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_fire) rd_data <= mem[rptr];
            rd_valid <= rd_fire;
            rd_last  <= last_fire;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wptr] <= i_data;
    end

    assign o_rd_data    = rd_data;
    assign o_rd_valid   = rd_valid;
    assign o_rd_last    = rd_last;
    assign o_full       = (state == DONE);
    assign o_state      = state;
    assign o_trig_index = p_lat;

endmodule

// File: tb/tb_capture_trigger_buffer.sv
// tb_capture_trigger_buffer: directed checks of capture_trigger_buffer with a 16-deep window.
module tb_capture_trigger_buffer;
    import capture_trigger_buffer_pkg::*;

    localparam int NB_DATA = 14;
    localparam int NB_ADDR = 4;

    logic               clock = 1'b0;
    logic               i_reset;
    logic               i_arm;
    logic               i_mode;
    logic               i_trigger;
    logic [NB_ADDR-1:0] i_pretrig;
    logic               i_valid;
    logic [NB_DATA-1:0] i_data;
    logic               i_rd_en;
    logic [NB_DATA-1:0] o_rd_data;
    logic               o_rd_valid;
    logic               o_rd_last;
    logic               o_full;
    logic [1:0]         o_state;
    logic [NB_ADDR-1:0] o_trig_index;

    int passed = 0;
    int total  = 0;

    capture_trigger_buffer #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_arm        (i_arm),
        .i_mode       (i_mode),
        .i_trigger    (i_trigger),
        .i_pretrig    (i_pretrig),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_rd_en      (i_rd_en),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .o_rd_last    (o_rd_last),
        .o_full       (o_full),
        .o_state      (o_state),
        .o_trig_index (o_trig_index)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        if (i_valid) i_data = i_data + 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic arm(input logic [NB_ADDR-1:0] p, input logic mode);
        i_pretrig = p;
        i_mode    = mode;
        i_trigger = 1'b0;
        i_valid   = 1'b0;
        i_arm     = 1'b1;
        tick();
        i_arm = 1'b0;
        chk("arm_state", 32'(o_state), 32'(ARMED));
        i_data  = '0;
        i_valid = 1'b1;
    endtask

    task automatic feed(input int n, input logic trig);
        i_trigger = trig;
        repeat (n) tick();
    endtask

    task automatic read_all(input int first, input logic [1:0] post_state);
        i_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rd_valid", 32'(o_rd_valid), 32'd1);
            chk("rd_data", 32'(o_rd_data), 32'(first + i));
            chk("rd_last", 32'(o_rd_last), 32'(i == 15));
        end
        chk("post_read_state", 32'(o_state), 32'(post_state));
        tick();
        chk("extra_req_valid", 32'(o_rd_valid), 32'd0);
        i_rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset   = 1'b0;
        i_arm     = 1'b0;
        i_mode    = 1'b0;
        i_trigger = 1'b0;
        i_pretrig = '0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_rd_en   = 1'b0;
        repeat (2) tick();
        chk("reset_state", 32'(o_state), 32'(IDLE));
        chk("reset_full", 32'(o_full), 32'd0);
        chk("reset_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("reset_rd_last", 32'(o_rd_last), 32'd0);
        chk("reset_rd_data", 32'(o_rd_data), 32'd0);
        chk("reset_trig_index", 32'(o_trig_index), 32'd0);
        i_reset = 1'b1;
        tick();

        // reset in the middle of a capture
        arm(4'd2, 1'b0);
        feed(4, 1'b0);
        feed(1, 1'b1);
        chk("a_capture", 32'(o_state), 32'(CAPTURE));
        feed(1, 1'b1);
        i_reset   = 1'b0;
        i_trigger = 1'b0;
        tick();
        chk("a_rst_state", 32'(o_state), 32'(IDLE));
        chk("a_rst_full", 32'(o_full), 32'd0);
        chk("a_rst_valid", 32'(o_rd_valid), 32'd0);
        i_reset = 1'b1;
        i_valid = 1'b0;
        tick();

        // P=5, trigger on sample 20, writes during DONE ignored
        arm(4'd5, 1'b0);
        feed(20, 1'b0);
        feed(1, 1'b1);
        chk("b_capture", 32'(o_state), 32'(CAPTURE));
        feed(9, 1'b1);
        chk("b_still_capture", 32'(o_state), 32'(CAPTURE));
        feed(1, 1'b1);
        chk("b_done", 32'(o_state), 32'(DONE));
        chk("b_full", 32'(o_full), 32'd1);
        chk("b_trig_index", 32'(o_trig_index), 32'd5);
        i_trigger = 1'b0;
        read_all(15, IDLE);
        i_valid = 1'b0;
        tick();

        // early edge discarded, later edge accepted
        arm(4'd5, 1'b0);
        feed(2, 1'b0);
        feed(1, 1'b1);
        chk("c_early_ignored", 32'(o_state), 32'(ARMED));
        feed(6, 1'b0);
        feed(1, 1'b1);
        chk("c_capture", 32'(o_state), 32'(CAPTURE));
        feed(10, 1'b1);
        chk("c_done", 32'(o_state), 32'(DONE));
        i_valid   = 1'b0;
        i_trigger = 1'b0;
        read_all(4, IDLE);

        // P=0 with auto re-arm, then a fresh window
        arm(4'd0, 1'b1);
        feed(3, 1'b0);
        feed(1, 1'b1);
        chk("d_capture", 32'(o_state), 32'(CAPTURE));
        feed(15, 1'b1);
        chk("d_done", 32'(o_state), 32'(DONE));
        i_valid   = 1'b0;
        i_trigger = 1'b0;
        read_all(3, ARMED);
        i_mode  = 1'b0;
        i_data  = 14'd100;
        i_valid = 1'b1;
        feed(2, 1'b0);
        feed(1, 1'b1);
        chk("d2_capture", 32'(o_state), 32'(CAPTURE));
        feed(15, 1'b1);
        chk("d2_done", 32'(o_state), 32'(DONE));
        i_valid   = 1'b0;
        i_trigger = 1'b0;
        read_all(102, IDLE);

        // P=15 with i_valid low during CAPTURE, then a toggling readout
        arm(4'd15, 1'b0);
        feed(15, 1'b0);
        i_valid   = 1'b0;
        i_trigger = 1'b1;
        tick();
        chk("e_capture", 32'(o_state), 32'(CAPTURE));
        repeat (4) begin
            tick();
            chk("e_gap_capture", 32'(o_state), 32'(CAPTURE));
        end
        i_valid = 1'b1;
        tick();
        chk("e_done", 32'(o_state), 32'(DONE));
        chk("e_trig_index", 32'(o_trig_index), 32'd15);
        i_valid   = 1'b0;
        i_trigger = 1'b0;
        begin
            int idx;
            idx = 0;
            for (int k = 0; k < 34; k++) begin
                i_rd_en = (k % 2 == 0);
                tick();
                if ((k % 2 == 0) && (idx < 16)) begin
                    chk("t_valid", 32'(o_rd_valid), 32'd1);
                    chk("t_data", 32'(o_rd_data), 32'(idx));
                    chk("t_last", 32'(o_rd_last), 32'(idx == 15));
                    idx++;
                end else begin
                    chk("t_no_valid", 32'(o_rd_valid), 32'd0);
                end
            end
            i_rd_en = 1'b0;
        end
        chk("t_final_state", 32'(o_state), 32'(IDLE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/capture_trigger_buffer.md
# capture_trigger_buffer

Parametrised trigger-armed sample capture buffer, the successor of the fixed FIR-output logger on the EAMTA board. It stores a stream of filter samples in an internal circular memory: a programmable number of samples before a trigger edge, then the rest of the buffer after it. A consumer (ILA probe, UART dumper) can then read the whole window out in chronological order. The block adds single-shot and auto re-arm modes, trigger qualification and a read handshake with a last flag.

## Interface
- NB_DATA, 14, sample width (bits)
- NB_ADDR, 11, address width; DEPTH = 2**NB_ADDR samples
- clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_arm  in  1  one-cycle arm pulse, honoured only in IDLE
- i_mode  in  1  0 = single-shot, 1 = auto re-arm after readout; sampled when readout completes
- i_trigger  in  1  synchronous trigger level (switch/comparator); rising edge detected internally
- i_pretrig  in  NB_ADDR  pre-trigger sample count P, latched on arm/re-arm
- i_valid  in  1  input sample strobe
- i_data  in  NB_DATA  input sample
- i_rd_en  in  1  read request, one sample per cycle
- o_rd_data  out  NB_DATA  read sample
- o_rd_valid  out  1  o_rd_data valid
- o_rd_last  out  1  with o_rd_valid, marks sample DEPTH-1 of the window
- o_full  out  1  high in DONE (capture complete, LED)
- o_state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- o_trig_index  out  NB_ADDR  readout index of first post-trigger sample (= latched P)

## Operation
- IDLE: no writes, no reads. i_arm -> ARMED. Clear wptr and pre_cnt; latch P = i_pretrig.
- ARMED: each i_valid writes mem[wptr] and increments wptr modulo DEPTH. pre_cnt saturates at P.
- A trigger rising edge is accepted only if pre_cnt == P. The check uses the value before this cycle's increment. Earlier edges are discarded, not queued.
- On acceptance: start_addr = wptr - P (mod DEPTH), post_cnt = DEPTH - P, go to CAPTURE. A sample valid in the trigger cycle is the first post-trigger sample.
- CAPTURE: writes continue and post_cnt decrements per write. When the write that makes post_cnt 0 occurs -> DONE. Trigger edges are ignored.
- DONE: writes ignored; o_full=1; rptr starts at start_addr.
  - Each i_rd_en reads mem[rptr], increments rptr mod DEPTH and increments rd_cnt.
  - The read with rd_cnt = DEPTH-1 produces o_rd_last.
  - After that request, the next state is IDLE (i_mode=0), or ARMED with wptr/pre_cnt cleared and P re-latched (i_mode=1).
- i_rd_en outside DONE, and i_rd_en after the last request has been issued, are ignored (no o_rd_valid).
- i_arm outside IDLE is ignored.
- P = 0: trigger accepted on the first edge after arm; the window is all post-trigger.
- P = DEPTH-1 is the maximum; the window then holds one post-trigger sample.
- Width rules: pointers wrap naturally at NB_ADDR bits. post_cnt is NB_ADDR+1 bits so DEPTH fits.

## Timing
- Reset: state IDLE; all outputs 0; wptr, rptr, pre_cnt, post_cnt, rd_cnt, edge-detect register, start_addr and latched P all 0. Memory contents are not reset.
- Trigger edge: detected in the cycle i_trigger first reads 1 after 0. State is CAPTURE the next cycle.
- Write: the memory takes i_data on the i_valid edge.
- Read latency: 1 cycle. i_rd_en at cycle n gives o_rd_data/o_rd_valid (and o_rd_last) at n+1.
- DONE->IDLE/ARMED happens on the edge of the last i_rd_en. The final o_rd_valid appears the cycle after, already outside DONE, and must still be driven.
- Read-during-write of the same address cannot occur: reads and writes are exclusive by state.
- Reset asserted mid-capture or mid-readout aborts immediately. No read data is emitted after reset.

## Structure
- Shared package holds the state encoding constants (IDLE/ARMED/CAPTURE/DONE) and the default NB_DATA/NB_ADDR values shared with the FIR and top levels.
- Sub-module rise_detect: one register plus AND, async active-low reset, output o_rise.
- Memory is an inferred simple dual-port array in this block. Write and read use separate ports; the read port is registered.

## Test plan
Bench settings: NB_ADDR=4 (DEPTH=16), data = incrementing counter starting at 0, i_valid=1 every cycle unless stated.
- Reset mid-CAPTURE -> next cycle o_state=0, o_full=0, o_rd_valid=0. A following arm/trigger run produces a correct window.
- P=5, trigger edge when sample 20 is written -> readout 15,16,…,30; o_trig_index=5; o_rd_last with value 30.
- P=5, trigger edge 2 samples after arm -> edge ignored. The next edge at sample 9 is accepted; readout 4..19.
- P=0, i_mode=1, trigger at sample 3 -> readout 3..18. State returns to ARMED on the last read. A second trigger then captures a fresh window.
- Readout with i_rd_en toggling 1,0,1 -> o_rd_valid follows one cycle later with no skipped or duplicated samples. 17 requests yield only 16 valids.
- i_valid low during CAPTURE for 4 cycles, P=15 -> the window still holds 16 samples with no gaps. DONE arrives 4 cycles later than with continuous i_valid.
